// File: rtl/tfc_delay_ctrl.sv
// Delay-line tap controller: arbitrates two delay requests, applies the new tap on orbit_sync, then masks TFC for target+2 cycles.
// tfc_out has 1-cycle latency; requesters are backpressured (ready low) outside IDLE and while rst is high.
module tfc_delay_ctrl #(
  parameter int TFC_WIDTH   = 8,
  parameter int LEN_WIDTH   = 8,
  parameter int MAX_LEN     = 200,
  parameter int DEFAULT_LEN = 16
) (
  input  logic                 main_clk,
  input  logic                 rst,
  input  logic                 req_a_valid,
  input  logic [LEN_WIDTH-1:0] req_a_len,
  output logic                 req_a_ready,
  input  logic                 req_b_valid,
  input  logic [LEN_WIDTH-1:0] req_b_len,
  output logic                 req_b_ready,
  input  logic                 orbit_sync,
  input  logic                 abort,
  output logic [LEN_WIDTH-1:0] fifo_len,
  input  logic [TFC_WIDTH-1:0] tfc_dp_in,
  output logic [TFC_WIDTH-1:0] tfc_out,
  output logic                 busy,
  output logic                 done,
  output logic                 err_range
);

  typedef enum logic [1:0] {IDLE, PENDING, FLUSH} state_t;

  localparam logic [LEN_WIDTH:0]   MAX_LEN_X = (LEN_WIDTH+1)'(MAX_LEN);
  localparam logic [LEN_WIDTH-1:0] DEF_LEN   = LEN_WIDTH'(DEFAULT_LEN);
  localparam logic [LEN_WIDTH:0]   CNT_ONE   = (LEN_WIDTH+1)'(1);

  state_t               state, state_nxt;
  logic [LEN_WIDTH-1:0] target, target_nxt;
  logic [LEN_WIDTH-1:0] fifo_len_nxt;
  logic [LEN_WIDTH:0]   cnt, cnt_nxt;
  logic                 done_nxt, err_nxt;
  logic                 last_grant, last_grant_nxt;  // 1 = B was granted last
  logic                 grant_a, grant_b, accept;
  logic [LEN_WIDTH-1:0] acc_len;

  always_comb begin
    grant_a        = req_a_valid && (!req_b_valid || last_grant);
    grant_b        = req_b_valid && !grant_a;
    req_a_ready    = !rst && (state == IDLE) && grant_a;
    req_b_ready    = !rst && (state == IDLE) && grant_b;
    accept         = req_a_ready || req_b_ready;
    acc_len        = req_a_ready ? req_a_len : req_b_len;
    busy           = (state != IDLE);

    state_nxt      = state;
    target_nxt     = target;
    fifo_len_nxt   = fifo_len;
    cnt_nxt        = cnt;
    done_nxt       = 1'b0;
    err_nxt        = 1'b0;
    last_grant_nxt = last_grant;

    case (state)
      IDLE: begin
        if (accept) begin
          last_grant_nxt = req_b_ready;
          if ({1'b0, acc_len} > MAX_LEN_X) begin
            err_nxt = 1'b1;
          end else if (acc_len == fifo_len) begin
            done_nxt = 1'b1;
          end else begin
            target_nxt = acc_len;
            state_nxt  = PENDING;
          end
        end
      end
      PENDING: begin
        // orbit_sync takes priority over a simultaneous abort
        if (orbit_sync) begin
          fifo_len_nxt = target;
          cnt_nxt      = {1'b0, target} + CNT_ONE;
          state_nxt    = FLUSH;
        end else if (abort) begin
          state_nxt = IDLE;
        end
      end
      FLUSH: begin
        if (cnt == '0) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge main_clk) begin
    if (rst) begin
      state      <= IDLE;
      target     <= '0;
      fifo_len   <= DEF_LEN;
      cnt        <= '0;
      done       <= 1'b0;
      err_range  <= 1'b0;
      last_grant <= 1'b1;
      tfc_out    <= '0;
    end else begin
      state      <= state_nxt;
      target     <= target_nxt;
      fifo_len   <= fifo_len_nxt;
      cnt        <= cnt_nxt;
      done       <= done_nxt;
      err_range  <= err_nxt;
      last_grant <= last_grant_nxt;
      tfc_out    <= (state == FLUSH) ? '0 : tfc_dp_in;
    end
  end

endmodule

// File: tb/tb_tfc_delay_ctrl.sv
// Directed bench for tfc_delay_ctrl: reset, flush timing, arbitration, range error, same-length, abort and mid-flush reset.
module tb_tfc_delay_ctrl;

  localparam logic [7:0] DP = 8'hA5;

  logic       main_clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_a_valid = 1'b0, req_b_valid = 1'b0;
  logic [7:0] req_a_len = '0, req_b_len = '0;
  logic       req_a_ready, req_b_ready;
  logic       orbit_sync = 1'b0, abort = 1'b0;
  logic [7:0] fifo_len, tfc_out;
  logic [7:0] tfc_dp_in = DP;
  logic       busy, done, err_range;

  int errors = 0;
  int checks = 0;

  tfc_delay_ctrl dut (
    .main_clk(main_clk), .rst(rst),
    .req_a_valid(req_a_valid), .req_a_len(req_a_len), .req_a_ready(req_a_ready),
    .req_b_valid(req_b_valid), .req_b_len(req_b_len), .req_b_ready(req_b_ready),
    .orbit_sync(orbit_sync), .abort(abort), .fifo_len(fifo_len),
    .tfc_dp_in(tfc_dp_in), .tfc_out(tfc_out),
    .busy(busy), .done(done), .err_range(err_range)
  );

  always #5 main_clk = ~main_clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic cycle();
    @(posedge main_clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_a_valid = 1'b1;
    req_a_len = 8'd40;
    cycle();
    cycle();
    checks++; if (fifo_len !== 8'd16) begin errors++; $display("FAIL reset_fifo_len: got %0d want 16", fifo_len); end
    checks++; if (tfc_out !== 8'h00) begin errors++; $display("FAIL reset_tfc_out: got %0h want 0", tfc_out); end
    checks++; if ({busy, done, err_range} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {busy, done, err_range}); end
    checks++; if (req_a_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", req_a_ready); end
    req_a_valid = 1'b0;
    rst = 1'b0;
    cycle();
    checks++; if (tfc_out !== DP) begin errors++; $display("FAIL reset_passthru: got %0h want %0h", tfc_out, DP); end
  endtask

  task automatic test_flush();
    int zero_cnt = 0, done_cnt = 0, done_idx = -1;
    req_a_valid = 1'b1;
    req_a_len = 8'd40;
    #1;
    checks++; if (req_a_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b want 1", req_a_ready); end
    cycle();
    req_a_valid = 1'b0;
    checks++; if ({busy, fifo_len} !== {1'b1, 8'd16}) begin errors++; $display("FAIL flush_pending: got busy=%b len=%0d want busy=1 len=16", busy, fifo_len); end
    repeat (4) cycle();
    orbit_sync = 1'b1;
    cycle();
    orbit_sync = 1'b0;
    checks++; if (fifo_len !== 8'd40) begin errors++; $display("FAIL flush_apply: got %0d want 40", fifo_len); end
    checks++; if (tfc_out !== DP) begin errors++; $display("FAIL flush_sync_edge_tfc: got %0h want %0h", tfc_out, DP); end
    for (int i = 0; i < 50; i++) begin
      cycle();
      if (tfc_out == 8'h00) zero_cnt++;
      if (done) begin done_cnt++; done_idx = i; end
    end
    checks++; if (zero_cnt !== 42) begin errors++; $display("FAIL flush_mask_len: got %0d want 42", zero_cnt); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL flush_done_count: got %0d want 1", done_cnt); end
    checks++; if (done_idx !== 41) begin errors++; $display("FAIL flush_done_time: got %0d want 41", done_idx); end
    checks++; if ({busy, tfc_out} !== {1'b0, DP}) begin errors++; $display("FAIL flush_end: got busy=%b tfc=%0h want busy=0 tfc=%0h", busy, tfc_out, DP); end
  endtask

  task automatic test_arbitration();
    bit seen;
    do_reset();
    req_a_valid = 1'b1; req_a_len = 8'd30;
    req_b_valid = 1'b1; req_b_len = 8'd50;
    #1;
    checks++; if ({req_a_ready, req_b_ready} !== 2'b10) begin errors++; $display("FAIL arb_first: got %b want 10", {req_a_ready, req_b_ready}); end
    cycle();
    checks++; if ({req_a_ready, req_b_ready} !== 2'b00) begin errors++; $display("FAIL arb_pending_ready: got %b want 00", {req_a_ready, req_b_ready}); end
    orbit_sync = 1'b1;
    cycle();
    orbit_sync = 1'b0;
    checks++; if (fifo_len !== 8'd30) begin errors++; $display("FAIL arb_len_a: got %0d want 30", fifo_len); end
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      cycle();
      seen = done;
    end
    checks++; if (!seen) begin errors++; $display("FAIL arb_done_a_timeout: got no done want done"); end
    checks++; if ({req_a_ready, req_b_ready} !== 2'b01) begin errors++; $display("FAIL arb_second: got %b want 01", {req_a_ready, req_b_ready}); end
    cycle();
    req_a_valid = 1'b0;
    req_b_valid = 1'b0;
    orbit_sync = 1'b1;
    cycle();
    orbit_sync = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 80 && !seen; i++) begin
      cycle();
      seen = done;
    end
    checks++; if (!seen) begin errors++; $display("FAIL arb_done_b_timeout: got no done want done"); end
    checks++; if (fifo_len !== 8'd50) begin errors++; $display("FAIL arb_final_len: got %0d want 50", fifo_len); end
  endtask

  task automatic test_range();
    do_reset();
    req_b_valid = 1'b1;
    req_b_len = 8'd201;
    #1;
    checks++; if (req_b_ready !== 1'b1) begin errors++; $display("FAIL range_ready: got %b want 1", req_b_ready); end
    cycle();
    req_b_valid = 1'b0;
    checks++; if ({err_range, busy, fifo_len} !== {2'b10, 8'd16}) begin errors++; $display("FAIL range_pulse: got err=%b busy=%b len=%0d want err=1 busy=0 len=16", err_range, busy, fifo_len); end
    cycle();
    checks++; if ({err_range, busy} !== 2'b00) begin errors++; $display("FAIL range_one_cycle: got %b want 00", {err_range, busy}); end
    req_a_valid = 1'b1;
    req_a_len = 8'd200;
    cycle();
    req_a_valid = 1'b0;
    checks++; if ({err_range, busy} !== 2'b01) begin errors++; $display("FAIL range_max_legal: got %b want 01", {err_range, busy}); end
    abort = 1'b1;
    cycle();
    abort = 1'b0;
  endtask

  task automatic test_same_len();
    do_reset();
    req_a_valid = 1'b1;
    req_a_len = 8'd16;
    cycle();
    req_a_valid = 1'b0;
    checks++; if ({done, busy, tfc_out} !== {2'b10, DP}) begin errors++; $display("FAIL same_done: got done=%b busy=%b tfc=%0h want 1 0 %0h", done, busy, tfc_out, DP); end
    cycle();
    checks++; if ({done, busy, tfc_out} !== {2'b00, DP}) begin errors++; $display("FAIL same_after: got done=%b busy=%b tfc=%0h want 0 0 %0h", done, busy, tfc_out, DP); end
  endtask

  task automatic test_abort();
    bit seen;
    do_reset();
    req_a_valid = 1'b1;
    req_a_len = 8'd100;
    cycle();
    req_a_valid = 1'b0;
    cycle();
    abort = 1'b1;
    orbit_sync = 1'b1;
    cycle();
    abort = 1'b0;
    orbit_sync = 1'b0;
    checks++; if ({busy, fifo_len} !== {1'b1, 8'd100}) begin errors++; $display("FAIL abort_sync_wins: got busy=%b len=%0d want 1 100", busy, fifo_len); end
    cycle();
    abort = 1'b1;
    orbit_sync = 1'b1;
    cycle();
    abort = 1'b0;
    orbit_sync = 1'b0;
    checks++; if ({busy, tfc_out} !== {1'b1, 8'h00}) begin errors++; $display("FAIL abort_ignored_flush: got busy=%b tfc=%0h want 1 0", busy, tfc_out); end
    seen = 1'b0;
    for (int i = 0; i < 150 && !seen; i++) begin
      cycle();
      seen = done;
    end
    checks++; if (!seen) begin errors++; $display("FAIL abort_done_timeout: got no done want done"); end
    req_a_valid = 1'b1;
    req_a_len = 8'd60;
    cycle();
    req_a_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_second_pending: got %b want 1", busy); end
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    checks++; if ({busy, done, fifo_len} !== {2'b00, 8'd100}) begin errors++; $display("FAIL abort_cancel: got busy=%b done=%b len=%0d want 0 0 100", busy, done, fifo_len); end
    cycle();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_no_done: got %b want 0", done); end
  endtask

  task automatic test_reset_flush();
    do_reset();
    req_a_valid = 1'b1;
    req_a_len = 8'd20;
    cycle();
    req_a_valid = 1'b0;
    orbit_sync = 1'b1;
    cycle();
    orbit_sync = 1'b0;
    repeat (3) cycle();
    checks++; if ({busy, tfc_out} !== {1'b1, 8'h00}) begin errors++; $display("FAIL rstflush_in_flush: got busy=%b tfc=%0h want 1 0", busy, tfc_out); end
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    checks++; if ({busy, done, fifo_len, tfc_out} !== {2'b00, 8'd16, 8'h00}) begin errors++; $display("FAIL rstflush_state: got busy=%b done=%b len=%0d tfc=%0h want 0 0 16 0", busy, done, fifo_len, tfc_out); end
    cycle();
    checks++; if ({done, tfc_out} !== {1'b0, DP}) begin errors++; $display("FAIL rstflush_after: got done=%b tfc=%0h want 0 %0h", done, tfc_out, DP); end
  endtask

  initial begin
    #1;
    test_reset();
    test_flush();
    test_arbitration();
    test_range();
    test_same_len();
    test_abort();
    test_reset_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
